eda_push_serializer: RTL
========================

# eda_push_serializer

Consumer side of the neighbour-push interface in the regional-maxima flow. It captures the 8-bit neighbour mask `push_positions` produced by the window comparator and drains it into the pixel-address FIFO one neighbour address per cycle, with FIFO back-pressure. It returns `iterated_idx` to the comparator so positions already handled are masked out. It sits between the comparator and the traversal FIFO.

## Interface
- `M`, 16, image rows
- `N`, 16, image columns
- `ADDR_WIDTH`, `$clog2(M*N)`, linear pixel address width
- `ROW_WIDTH`, `$clog2(M)`, row index width
- `COL_WIDTH`, `$clog2(N)`, column index width

Ports:
- `clk`  in  1  clock; one clock domain
- `reset`  in  1  synchronous, active-high reset
- `new_pixel`  in  1  start of a new centre pixel; same pulse the comparator receives
- `center_row`  in  ROW_WIDTH  row of the current centre pixel
- `center_col`  in  COL_WIDTH  column of the current centre pixel
- `push_positions`  in  8  neighbour mask; bit order is window 0,1,2,3,5,6,7,8 of a row-major 3x3, centre excluded
- `fifo_full`  in  1  FIFO cannot accept a write this cycle
- `fifo_push`  out  1  FIFO write strobe
- `fifo_data`  out  ADDR_WIDTH  neighbour linear address, row*N+col
- `iterated_idx`  out  8  positions captured for the current pixel; fed back to the comparator
- `busy`  out  1  FSM in DRAIN
- `done`  out  1  one-cycle pulse when the last pending address is pushed
- `overrun`  out  1  one-cycle pulse when `new_pixel` discards pending work

## Operation
- State: FSM {IDLE, DRAIN}, 8-bit `pending`, 8-bit `iterated_idx`, latched `crow` and `ccol`.
- Capture: on a cycle with `new_pixel`=0 and `push_positions & ~iterated_idx` nonzero:
  - OR the new bits into `pending` and into `iterated_idx`.
  - If in IDLE, latch `center_row`/`center_col` and go to DRAIN.
  - If already in DRAIN, the latched centre is kept.
- Drain: selected bit = lowest set bit of `pending`.
  - Bits 0..3 map to window k = bit; bits 4..7 map to window k = bit+1.
  - Neighbour offset: dr = k/3 − 1, dc = k%3 − 1.
  - `fifo_data` = (crow+dr)*N + (ccol+dc), computed at ADDR_WIDTH bits with modulo wrap.
- `fifo_push` = (state==DRAIN) && !`fifo_full`. When asserted, the selected bit clears in `pending` at the next edge.
- Leaving DRAIN: when the push removes the last pending bit and no capture occurs in the same cycle, go to IDLE and pulse `done`.
- Capture in the same cycle as a push: the new bits are added after the pushed bit is cleared. Stay in DRAIN if anything remains; no `done`.
- `new_pixel` has top priority:
  - Clears `iterated_idx` and `pending`; ignores `push_positions` that cycle.
  - FSM goes to IDLE; `fifo_push` is still driven combinationally that cycle.
  - If `pending` was nonzero, pulse `overrun`.
- `fifo_full` held high: state and `pending` hold indefinitely, `fifo_push`=0.

## Timing
- Reset values: state IDLE, `pending`=0, `iterated_idx`=0, `crow`/`ccol`=0. Outputs: `fifo_push`=0, `fifo_data`=0, `busy`=0, `done`=0, `overrun`=0.
- Capture at edge t gives first `fifo_push` during cycle t+1 (if not full). Throughput is one address per cycle.
- A mask with P bits and no stalls needs P push cycles. `done` is high during the cycle after the last push edge.
- `iterated_idx` updates at the capture edge. The comparator therefore sees captured bits masked one cycle after presenting them.
- `fifo_push` and `fifo_data` are combinational from registers and `fifo_full`. There is no combinational path from `push_positions` to them.

## Configuration
- `EDA_PUSH_BOUNDS_CHECK_EN` defined:
  - At capture, mask off bits whose neighbour falls outside 0..M-1 or 0..N-1 (based on `center_row`/`center_col`).
  - Any bit removed pulses an extra output `bound_err` (1 bit, reset 0) for one cycle.
  - Removed bits are still set in `iterated_idx`.
- Macro not defined: the mask is trusted as already validated upstream; `bound_err` port is absent and addresses wrap modulo 2^ADDR_WIDTH.

## Test plan
- M=N=16, centre (5,7), mask 8'b1000_0001, `fifo_full`=0: pushes 70 then 104 on consecutive cycles, `done` the next cycle, `iterated_idx`=8'h81.
- Mask 8'hFF at centre (5,7): pushes 70,71,72,86,88,102,103,104 in order; `busy` high for exactly 8 cycles.
- Mask 8'h03, `fifo_full` high for 3 cycles after capture: no push while full, then 70 and 71 back-to-back.
- Mask 8'h01 draining and stalled, then mask 8'h10 presented: 8'h10 is merged, `iterated_idx`=8'h11; 70 then 88 are pushed with a single `done`.
- Mask 8'h0F captured, `new_pixel` asserted after one push: `overrun` pulses, `iterated_idx`=0, IDLE, no further pushes.
- Macro defined, centre (0,0), mask 8'hFF: only 1, 16, 17 pushed; `bound_err` pulses once; `iterated_idx`=8'hFF.

Source files
------------

// File: rtl/eda_push_serializer.sv
// eda_push_serializer
//
// Consumer side of the neighbour-push interface. Captures the 8-bit
// neighbour mask from the window comparator. Drains it into the
// pixel-address FIFO one linear address per cycle, lowest mask bit first.
// Returns the set of already-captured positions so the comparator can mask
// them out.
//
// Optional feature macro: EDA_PUSH_BOUNDS_CHECK_EN
//   When defined, neighbours outside the image are dropped at capture and
//   reported on bound_err.
//   When undefined, the mask is trusted, bound_err is absent, and addresses
//   wrap modulo 2^ADDR_WIDTH.
//
// Ports:
//   clk, reset     - clock, synchronous active-high reset
//   new_pixel      - start of a new centre pixel (top priority)
//   center_row/col - centre pixel coordinates, latched when capture starts
//   push_positions - neighbour mask, window order 0,1,2,3,5,6,7,8
//   fifo_full      - FIFO back-pressure
//   fifo_push      - FIFO write strobe
//   fifo_data      - neighbour linear address row*N+col
//   iterated_idx   - positions captured for the current pixel
//   busy           - draining
//   done           - pulse after the last pending address is pushed
//   bound_err      - (macro only) pulse when out-of-image bits are dropped
//   overrun        - pulse when new_pixel discards pending work
module eda_push_serializer #(
  parameter int M          = 16,
  parameter int N          = 16,
  parameter int ADDR_WIDTH = $clog2(M*N),
  parameter int ROW_WIDTH  = $clog2(M),
  parameter int COL_WIDTH  = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  new_pixel,
  input  logic [ROW_WIDTH-1:0]  center_row,
  input  logic [COL_WIDTH-1:0]  center_col,
  input  logic [7:0]            push_positions,
  input  logic                  fifo_full,
  output logic                  fifo_push,
  output logic [ADDR_WIDTH-1:0] fifo_data,
  output logic [7:0]            iterated_idx,
  output logic                  busy,
  output logic                  done,
`ifdef EDA_PUSH_BOUNDS_CHECK_EN
  output logic                  bound_err,
`endif
  output logic                  overrun
);

  typedef enum logic {IDLE, DRAIN} state_e;

  state_e               state_q, state_d;
  logic [7:0]           pending_q, pending_d;
  logic [7:0]           iter_idx_q, iter_idx_d;
  logic [ROW_WIDTH-1:0] crow_q, crow_d;
  logic [COL_WIDTH-1:0] ccol_q, ccol_d;
  logic                 done_q, done_d;
  logic                 overrun_q, overrun_d;
`ifdef EDA_PUSH_BOUNDS_CHECK_EN
  logic                 bound_err_q, bound_err_d;
  logic [7:0]           oob;
`endif

  logic [7:0]            new_bits;
  logic [7:0]            keep_bits;
  logic [7:0]            pend_left;
  logic [2:0]            sel_idx;
  logic [7:0]            sel_oh;
  logic [ADDR_WIDTH-1:0] base_addr;

  // Linear offset of each mask bit from the centre pixel. The bits skip
  // window position 4, which is the centre itself.
  function automatic logic [ADDR_WIDTH-1:0] nbr_off(input logic [2:0] b);
    int off;
    case (b)
      3'd0:    off = -N - 1;
      3'd1:    off = -N;
      3'd2:    off = -N + 1;
      3'd3:    off = -1;
      3'd4:    off = 1;
      3'd5:    off = N - 1;
      3'd6:    off = N;
      default: off = N + 1;
    endcase
    return ADDR_WIDTH'(off);
  endfunction

  // Lowest set pending bit. Scanning from 7 down leaves the lowest bit as
  // the last assignment.
  always_comb begin
    sel_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (pending_q[i]) sel_idx = 3'(i);
    end
    sel_oh = 8'b1 << sel_idx;
  end

  assign base_addr = ADDR_WIDTH'(crow_q) * ADDR_WIDTH'(N) + ADDR_WIDTH'(ccol_q);

  // Outputs depend only on registers and fifo_full. fifo_data is zeroed
  // outside DRAIN so it does not show a stale neighbour address.
  assign fifo_push    = (state_q == DRAIN) && !fifo_full;
  assign fifo_data    = (state_q == DRAIN) ? base_addr + nbr_off(sel_idx) : '0;
  assign iterated_idx = iter_idx_q;
  assign busy         = (state_q == DRAIN);
  assign done         = done_q;
  assign overrun      = overrun_q;
`ifdef EDA_PUSH_BOUNDS_CHECK_EN
  assign bound_err    = bound_err_q;

  // Neighbours that fall outside the image, judged from the incoming centre.
  always_comb begin
    logic top, bot, lft, rgt;
    top    = (center_row == '0);
    bot    = (center_row == ROW_WIDTH'(M - 1));
    lft    = (center_col == '0);
    rgt    = (center_col == COL_WIDTH'(N - 1));
    oob    = {bot | rgt, bot, bot | lft, rgt, lft, top | rgt, top, top | lft};
  end
`endif

  always_comb begin
    // NOTE: every signal gets a default first, so no path through this block
    // leaves a value unassigned and no latch is inferred.
    state_d    = state_q;
    pending_d  = pending_q;
    iter_idx_d = iter_idx_q;
    crow_d     = crow_q;
    ccol_d     = ccol_q;
    done_d     = 1'b0;
    overrun_d  = 1'b0;
`ifdef EDA_PUSH_BOUNDS_CHECK_EN
    bound_err_d = 1'b0;
`endif

    new_bits  = push_positions & ~iter_idx_q;
`ifdef EDA_PUSH_BOUNDS_CHECK_EN
    keep_bits = new_bits & ~oob;
`else
    keep_bits = new_bits;
`endif
    pend_left = fifo_push ? (pending_q & ~sel_oh) : pending_q;

    if (new_pixel) begin
      // Abandons the current pixel. A push driven this cycle still happens.
      state_d    = IDLE;
      pending_d  = '0;
      iter_idx_d = '0;
      overrun_d  = |pending_q;
    end else begin
      // Captured bits merge after the pushed bit has been removed.
      pending_d  = pend_left | keep_bits;
      iter_idx_d = iter_idx_q | new_bits;
`ifdef EDA_PUSH_BOUNDS_CHECK_EN
      bound_err_d = |(new_bits & ~keep_bits);
`endif
      if (state_q == IDLE) begin
        if (|keep_bits) begin
          state_d = DRAIN;
          crow_d  = center_row;
          ccol_d  = center_col;
        end
      end else if (pending_d == '0) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only. All flops
  // then update together at the edge, whatever the order of the statements.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      iter_idx_q <= '0;
      crow_q     <= '0;
      ccol_q     <= '0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
`ifdef EDA_PUSH_BOUNDS_CHECK_EN
      bound_err_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      iter_idx_q <= iter_idx_d;
      crow_q     <= crow_d;
      ccol_q     <= ccol_d;
      done_q     <= done_d;
      overrun_q  <= overrun_d;
`ifdef EDA_PUSH_BOUNDS_CHECK_EN
      bound_err_q <= bound_err_d;
`endif
    end
  end

endmodule
